// File: rtl/nn_pkg.sv
// Shared types, constants and fp16 helpers for the neuron layer sequencer.
package nn_pkg;

  localparam int FP16_W = 16;
  // Signed fixed-point accumulator with 24 fraction bits (LSB = 2^-24, the fp16 subnormal step).
  localparam int ACC_W  = 50;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [FP16_W-1:0] ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] SIX  = 16'h4600;
  localparam logic [FP16_W-1:0] ONE  = 16'h3C00;
  localparam logic signed [ACC_W-1:0] SIX_FIX = 50'sd100663296;  // 6.0 * 2^24

  // Exact product of two fp16 values in accumulator units. Tiny products are
  // truncated, and products too large to matter after the clip saturate.
  // Inf/NaN encodings are treated as ordinary large numbers.
  function automatic logic signed [ACC_W-1:0] fp16_mul_fix(input logic [FP16_W-1:0] a,
                                                          input logic [FP16_W-1:0] b);
    logic [4:0]       ea, eb;
    logic [10:0]      ma, mb;
    logic [21:0]      mp;
    logic [ACC_W-1:0] mag;
    int               s;
    ea  = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    eb  = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    ma  = {|a[14:10], a[9:0]};
    mb  = {|b[14:10], b[9:0]};
    mp  = 22'(ma) * 22'(mb);
    s   = int'(ea) + int'(eb) - 26;
    if (s > 21) begin
      mag = ACC_W'({44{1'b1}});
    end else if (s >= 0) begin
      mag = ACC_W'(mp) << s;
    end else begin
      mag = ACC_W'(mp >> (-s));
    end
    return (a[15] ^ b[15]) ? -$signed(mag) : $signed(mag);
  endfunction

  // ReLU6 of an accumulator value, converted to fp16 with truncation.
  function automatic logic [FP16_W-1:0] fix_to_relu6(input logic signed [ACC_W-1:0] acc);
    logic [FP16_W-1:0] res;
    logic [26:0]       v;
    int                p;
    v = acc[26:0];
    p = 0;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) p = i;
    end
    if (acc <= $signed({ACC_W{1'b0}})) begin
      res = ZERO;
    end else if (acc >= SIX_FIX) begin
      res = SIX;
    end else if (p < 10) begin
      res = {6'd0, v[9:0]};
    end else begin
      res = {1'b0, 5'(p - 9), 10'(v >> (p - 10))};
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// Activation input, weight-memory and result signals of the layer sequencer.
interface neuron_layer_sequencer_if #(
  parameter int N  = 4,
  parameter int M  = 8,
  parameter int AW = 8
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic [nn_pkg::FP16_W*N-1:0]  in_vec;
  logic [AW-1:0]                cfg_base;
  logic                         w_rd_en;
  logic [AW-1:0]                w_addr;
  logic [nn_pkg::FP16_W*N-1:0]  w_data;
  logic [nn_pkg::FP16_W-1:0]    b_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [nn_pkg::FP16_W*M-1:0]  out_vec;
  logic                         busy;

  modport slave (
    input  in_valid, in_vec, cfg_base, w_data, b_data, out_ready,
    output in_ready, w_rd_en, w_addr, out_valid, out_vec, busy
  );

  modport master (
    output in_valid, in_vec, cfg_base, w_data, b_data, out_ready,
    input  in_ready, w_rd_en, w_addr, out_valid, out_vec, busy
  );
endinterface

// File: rtl/neuron.sv
// Combinational N-input fp16 dot product plus bias, followed by ReLU6.
module neuron
  import nn_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [FP16_W*N-1:0] i_x,
  input  logic [FP16_W*N-1:0] i_w,
  input  logic [FP16_W-1:0]   i_b,
  output logic [FP16_W-1:0]   o_y
);

  logic signed [ACC_W-1:0] w_acc;

  // Accumulate bias and all element products in exact fixed point.
  always_comb begin
    w_acc = fp16_mul_fix(i_b, ONE);
    for (int i = 0; i < N; i++) begin
      w_acc = w_acc + fp16_mul_fix(i_x[FP16_W*i +: FP16_W], i_w[FP16_W*i +: FP16_W]);
    end
  end

  assign o_y = fix_to_relu6(w_acc);

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes one neuron over the M outputs of a fully connected layer.
module neuron_layer_sequencer
  import nn_pkg::*;
#(
  parameter int N  = 4,
  parameter int M  = 8,
  parameter int AW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  neuron_layer_sequencer_if.slave  bus
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [FP16_W*N-1:0] r_act;
  logic [AW-1:0]       r_base;
  logic [AW-1:0]       r_addr;
  logic                r_rd_en;
  logic [IW-1:0]       r_k;
  logic                r_rd_vld;
  logic [IW-1:0]       r_rd_idx;
  logic [FP16_W*N-1:0] r_op_w;
  logic [FP16_W-1:0]   r_op_b;
  logic                r_op_vld;
  logic [IW-1:0]       r_op_idx;
  logic [FP16_W*M-1:0] r_out_vec;
  logic                r_out_valid;
  logic [FP16_W-1:0]   w_nrn_y;
  logic                w_accept;
  logic                w_last_issue;
  logic                w_last_capture;

  assign w_accept       = (r_state == IDLE) && bus.in_valid;
  assign w_last_issue   = (r_state == RUN) && (r_k == LAST_IDX);
  assign w_last_capture = r_op_vld && (r_op_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)   w_state_nxt = RUN;   else w_state_nxt = IDLE;
      RUN:     if (w_last_issue)   w_state_nxt = DRAIN; else w_state_nxt = RUN;
      DRAIN:   if (w_last_capture) w_state_nxt = DONE;  else w_state_nxt = DRAIN;
      DONE:    if (bus.out_ready)  w_state_nxt = IDLE;  else w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Job latch and read issue: one row address per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en <= 1'b0;
      r_addr  <= '0;
      r_base  <= '0;
      r_act   <= '0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_rd_en <= 1'b1;
      r_addr  <= bus.cfg_base;
      r_base  <= bus.cfg_base;
      r_act   <= bus.in_vec;
      r_k     <= '0;
    end else if (r_state == RUN) begin
      if (w_last_issue) begin
        r_rd_en <= 1'b0;
      end else begin
        r_k    <= r_k + IW'(1);
        r_addr <= r_base + AW'(r_k) + AW'(1);
      end
    end else begin
      r_rd_en <= 1'b0;
    end
  end

  // Read-return tracking and operand registers for the neuron.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
      r_rd_idx <= '0;
      r_op_vld <= 1'b0;
      r_op_idx <= '0;
      r_op_w   <= '0;
      r_op_b   <= '0;
    end else begin
      r_rd_vld <= r_rd_en;
      r_rd_idx <= r_k;
      r_op_vld <= r_rd_vld;
      if (r_rd_vld) begin
        r_op_w   <= bus.w_data;
        r_op_b   <= bus.b_data;
        r_op_idx <= r_rd_idx;
      end
    end
  end

  neuron #(.N(N)) u_neuron (
    .i_x (r_act),
    .i_w (r_op_w),
    .i_b (r_op_b),
    .o_y (w_nrn_y)
  );

  // Result capture into the output slot and result-valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vec   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_op_vld) begin
        r_out_vec[FP16_W*r_op_idx +: FP16_W] <= w_nrn_y;
      end
      if (w_last_capture) begin
        r_out_valid <= 1'b1;
      end else if ((r_state == DONE) && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.w_rd_en   = r_rd_en;
  assign bus.w_addr    = r_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_vec   = r_out_vec;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Self-checking bench for neuron_layer_sequencer with a real-valued layer model.
module tb_neuron_layer_sequencer;

  localparam int N  = 4;
  localparam int M  = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  neuron_layer_sequencer_if #(.N(N), .M(M), .AW(AW)) bus ();
  neuron_layer_sequencer #(.N(N), .M(M), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [16*N-1:0] wmem [256];
  logic [15:0]     bmem [256];
  logic [15:0]     wtab [8];

  // Synchronous weight memory: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.w_rd_en) begin
      bus.w_data <= wmem[bus.w_addr];
      bus.b_data <= bmem[bus.w_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e;
    real v;
    e = int'(h[14:10]);
    if (e == 0) v = real'(int'(h[9:0])) * pow2(-24);
    else        v = real'(1024 + int'(h[9:0])) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  // ReLU6 then fp16 encoding, rounding toward zero.
  function automatic logic [15:0] r2h(input real v);
    int ex;
    int m;
    if (v <= 0.0) return 16'h0000;
    if (v >= 6.0) return 16'h4600;
    if (v < pow2(-14)) return {6'd0, 10'($rtoi(v * pow2(24)))};
    ex = 2;
    while (pow2(ex) > v) ex--;
    m = $rtoi((v / pow2(ex) - 1.0) * 1024.0);
    return {1'b0, 5'(ex + 15), 10'(m)};
  endfunction

  function automatic logic [127:0] model_vec(input logic [63:0] x, input logic [7:0] base);
    logic [127:0] r;
    logic [7:0]   row;
    logic [63:0]  w;
    real          s;
    r = '0;
    for (int j = 0; j < M; j++) begin
      row = 8'(base + 8'(j));
      w   = wmem[row];
      s   = h2r(bmem[row]);
      for (int i = 0; i < N; i++) s = s + h2r(x[16*i +: 16]) * h2r(w[16*i +: 16]);
      r[16*j +: 16] = r2h(s);
    end
    return r;
  endfunction

  bit           job = 1'b0;
  bit           pend_acc = 1'b0;
  bit           pend_done = 1'b0;
  int           t = 0;
  logic [7:0]   p_base = 8'h00;
  logic [63:0]  p_vec = 64'h0;
  logic [127:0] exp_vec = 128'h0;

  // Per-cycle comparison of every DUT output against the job-level model.
  always @(negedge clk) begin
    if (rst) begin
      job = 1'b0; pend_acc = 1'b0; pend_done = 1'b0;
      check("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
      check("rst_rd_en", 128'(bus.w_rd_en), 128'(1'b0));
      check("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
      check("rst_busy", 128'(bus.busy), 128'(1'b0));
      check("rst_out_vec", bus.out_vec, 128'h0);
    end else begin
      if (pend_acc) begin
        job = 1'b1; t = 0; exp_vec = model_vec(p_vec, p_base);
      end else if (job) begin
        t++;
      end
      if (pend_done) job = 1'b0;
      pend_acc = 1'b0; pend_done = 1'b0;
      check("in_ready", 128'(bus.in_ready), 128'(!job));
      check("busy", 128'(bus.busy), 128'(job));
      check("rd_en", 128'(bus.w_rd_en), 128'(job && t < M));
      if (job && t < M) check("w_addr", 128'(bus.w_addr), 128'(8'(p_base + 8'(t))));
      check("out_valid", 128'(bus.out_valid), 128'(job && t >= M + 2));
      if (job && t >= M + 2) check("out_vec", bus.out_vec, exp_vec);
      if (!job && bus.in_valid) begin
        pend_acc = 1'b1; p_vec = bus.in_vec; p_base = bus.cfg_base;
      end
      pend_done = job && (t >= M + 2) && bus.out_ready;
    end
  end

  // One job: accept, scramble inputs, wait for result, backpressure, release.
  task automatic run_job(input logic [7:0] base, input logic [63:0] vec, input int hold,
                         output logic [127:0] got);
    int lat;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.cfg_base = base; bus.in_vec = vec;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.cfg_base = ~base; bus.in_vec = ~vec;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 128'(lat), 128'(M + 2));
    got = bus.out_vec;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (i == 2);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("in_ready_after_done", 128'(bus.in_ready), 128'(1'b1));
  endtask

  logic [127:0] got;
  logic [127:0] pin;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_vec = '0; bus.cfg_base = '0; bus.out_ready = 1'b0;
    wtab[0] = 16'h0000; wtab[1] = 16'h3800; wtab[2] = 16'hB800; wtab[3] = 16'h3C00;
    wtab[4] = 16'hBC00; wtab[5] = 16'h4000; wtab[6] = 16'hC000; wtab[7] = 16'h3400;
    for (int r = 0; r < 256; r++) begin
      for (int i = 0; i < N; i++) wmem[r][16*i +: 16] = wtab[(r * 3 + i * 5) % 8];
      bmem[r] = wtab[(r * 5) % 8];
    end
    for (int r = 8'h10; r < 8'h18; r++) begin
      wmem[r] = {4{16'h3C00}}; bmem[r] = 16'h0000;
    end
    wmem[8'h20] = {16'h3C00, 16'h4000, 16'hBC00, 16'h3800}; bmem[8'h20] = 16'h3800;
    wmem[8'h31] = {4{16'h4000}}; bmem[8'h31] = 16'h0000;

    check("pin_four", 128'(r2h(4.0)), 128'(16'h4400));
    check("pin_neg", 128'(r2h(-2.0)), 128'(16'h0000));
    check("pin_clip", 128'(r2h(16.0)), 128'(16'h4600));
    check("pin_2p5", 128'(r2h(h2r(16'h3800) + h2r(16'h4000))), 128'(16'h4100));
    pin = model_vec({4{16'h3C00}}, 8'h10);
    check("pin_model_row", 128'(pin[15:0]), 128'(16'h4400));

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_job(8'h10, {4{16'h3C00}}, 5, got);
    for (int j = 0; j < M; j++) check("nominal_slot", 128'(got[16*j +: 16]), 128'(16'h4400));

    run_job(8'h20, {16'hBC00, 16'h0000, 16'h4000, 16'h3C00}, 2, got);
    check("mixed_neg_slot0", 128'(got[15:0]), 128'(16'h0000));

    run_job(8'h30, {4{16'h4000}}, 1, got);
    check("clip_slot1", 128'(got[31:16]), 128'(16'h4600));

    run_job(8'hFE, {16'hBC00, 16'h4000, 16'h3800, 16'h3C00}, 0, got);

    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.cfg_base = 8'h10; bus.in_vec = {4{16'h3C00}};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (14) @(posedge clk);

    run_job(8'h10, {4{16'h3C00}}, 1, got);
    check("after_reset_slot0", 128'(got[15:0]), 128'(16'h4400));
    check("after_reset_slot7", 128'(got[127:112]), 128'(16'h4400));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
Time-multiplexes one `neuron` instance (N-input fp16 MAC + bias + ReLU6) across the M output neurons of a fully-connected layer. It accepts one N-element activation vector and fetches each neuron's weight row and bias from an external synchronous weight memory. It issues one neuron per cycle through a 2-stage pipeline and returns the M-element fp16 result vector on a valid/ready output. It sits between the activation stream and the weight store, one instance per layer.

Parameters:
N, 4, neuron fan-in (activations per vector, weights per row)
M, 8, neurons in the layer (output vector length); M >= 1
AW, 8, weight-memory address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  activation vector valid
in_ready  out  1  sequencer can accept a vector
in_vec  in  16*N  fp16 activations; element i at [16*i+15:16*i]
cfg_base  in  AW  weight-memory base address of this layer, sampled with the input handshake
w_rd_en  out  1  weight-memory read strobe
w_addr  out  AW  weight-memory row address
w_data  in  16*N  weight row; valid exactly 1 cycle after w_rd_en
b_data  in  16  fp16 bias of the same row; same timing as w_data
out_valid  out  1  result vector valid
out_ready  in  1  downstream accepts result
out_vec  out  16*M  fp16 ReLU6 results; neuron j at [16*j+15:16*j]
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE; w_rd_en=0, w_addr=0, out_valid=0, busy=0, out_vec=0; all pipeline valids, counters, operand regs and latched cfg_base clear. in_ready decodes state, so it reads 1 during and after reset.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge E0: latch in_vec and cfg_base, set issue count k=0, go to RUN.
- RUN, cycle k (k=0..M-1): w_rd_en=1, w_addr=(base+k) mod 2^AW. After issuing k=M-1, go to DRAIN.
- Pipeline stage 1: in the cycle after read k, w_data/b_data are registered into the operand regs with op_idx=k and op_vld=1.
- Pipeline stage 2: the neuron sees the latched in_vec and the operand regs. When op_vld, nrn result is written into out_vec slot op_idx at the next edge.
- DRAIN: w_rd_en=0. Lasts 2 cycles. Go to DONE when the last slot (M-1) is captured.
- Timing: out_valid rises M+2 edges after E0 (10 cycles for M=8). Throughput is one neuron per cycle.
- DONE: out_valid=1. out_vec is held stable until out_ready. On out_valid&out_ready, go to IDLE; in_ready=1 on the next cycle. Back-to-back jobs are therefore separated by at least 1 IDLE cycle.
- in_valid is ignored outside IDLE. in_vec and cfg_base changing after acceptance have no effect.
- out_vec slots are not cleared between jobs. Every slot is overwritten by each job.
- Address wrap: base+k wraps modulo 2^AW with no error.
- Arithmetic: entirely inside `neuron`. The sequencer does not modify data widths. Operands are 16-bit fp16 and the result is 16-bit fp16 clipped to [0, 6.0].
- Reset mid-RUN/DRAIN/DONE: the job is abandoned. w_rd_en drops immediately and no further captures occur. The next accepted job completes normally.

Decomposition:
- Package nn_pkg:
  - fp16 width constant (16)
  - state enum {IDLE, RUN, DRAIN, DONE}
  - fp16 constants ZERO=16'h0000, SIX=16'h4600
- Sub-module: the existing `neuron #(N)`, instantiated once, combinational, between operand regs and the capture register.
- The FSM, counters and pipeline are local to this module.

Test Plan:
1. Reset: assert rst for 3 cycles -> out_valid=0, w_rd_en=0, busy=0, out_vec=0, in_ready=1.
2. Nominal job (M=8, cfg_base=8'h10): every row has weights all 16'h3C00, bias 0; in_vec all 16'h3C00 -> w_addr 10..17 on consecutive cycles; out_valid exactly 10 cycles after accept; all 8 slots = 16'h4400 (4.0).
3. Mixed values:
   - Row 0 negative case: in_vec {1.0,2.0,0.0,-1.0} = {3C00,4000,0000,BC00}; weights {0.5,-1.0,2.0,1.0} = {3800,BC00,4000,3C00}; bias 3800 -> sum -2.0 -> slot0=16'h0000.
   - Row 1 clip case: weights all 4000 with in_vec all 4000 -> 16.0 -> slot1=16'h4600 (ReLU6 clip).
4. Backpressure: hold out_ready=0 for 5 cycles in DONE, pulse in_valid -> out_valid stays 1, out_vec unchanged, in_ready=0, no read issued. Release out_ready -> IDLE next cycle, in_ready=1.
5. Address wrap: cfg_base=8'hFE -> w_addr sequence FE,FF,00,01,02,03,04,05; results correct for those rows.
6. Reset mid-RUN: assert rst in RUN cycle 3 -> w_rd_en=0 and out_vec=0 immediately, no out_valid. A new job afterwards matches scenario 2.
